// File: rtl/usb_fifo_pkg.sv
// rtl/usb_fifo_pkg.sv - shared sizing helpers for the USB packet FIFO
// Each memory entry carries the packet-last flag above the payload.
`ifndef USB_FIFO_ENTRY_W
`define USB_FIFO_ENTRY_W(dw) ((dw) + 1)
`endif

package usb_fifo_pkg;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Bit position of the last flag within an entry of the given payload width.
  function automatic int last_bit(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM with registered read port
// Only the read register is reset; the array itself holds no reset.
module sdp_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read register doubles as the FIFO head stage, so it holds when re is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/usb_pkt_fifo.sv
// rtl/usb_pkt_fifo.sv - packet FIFO with commit/rollback and FWFT read
// Words become readable only once their packet's last word is committed.
module usb_pkt_fifo
  import usb_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int AFULL_LVL = DEPTH - 8,
  parameter int PKT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_last,
  input  logic                     wr_discard,
  output logic                     wr_ready,
  output logic                     wr_afull,
  output logic                     wr_overflow,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_last,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [PKT_W-1:0]         pkt_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int EW = `USB_FIFO_ENTRY_W(DATA_W);
  localparam int LB = last_bit(DATA_W);
  localparam logic [PW-1:0]    AFULL_V = PW'(AFULL_LVL);
  localparam logic [PKT_W-1:0] PKT_MAX = '1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] head_ptr;
  logic          drop;
  logic          full;
  logic          rewind;
  logic          accept;
  logic          commit;
  logic          rd_fire;
  logic          load;
  logic [EW-1:0] ram_q;

  // The word sitting in the head register still occupies its slot until consumed.
  assign head_ptr = rd_ptr - PW'(rd_valid);
  assign full     = (wr_ptr[PW-1] != head_ptr[PW-1]) &&
                    (wr_ptr[AW-1:0] == head_ptr[AW-1:0]);
  assign level    = wr_ptr - head_ptr;
  assign wr_ready = !full && !rst;
  assign wr_afull = level >= AFULL_V;

  assign rewind  = wr_discard || (drop && wr_valid && wr_last);
  assign accept  = wr_valid && wr_ready && !drop && !wr_discard;
  assign commit  = accept && wr_last;
  assign rd_fire = rd_valid && rd_ready;
  assign load    = (rd_ptr != commit_ptr) && (!rd_valid || rd_ready);

  assign rd_data = ram_q[DATA_W-1:0];
  assign rd_last = ram_q[LB];

  sdp_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({wr_last, wr_data}),
    .re    (load),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      drop        <= 1'b0;
      rd_valid    <= 1'b0;
      wr_overflow <= 1'b0;
      pkt_count   <= '0;
    end else begin
      wr_overflow <= wr_valid && !wr_ready;

      if (rewind) begin
        wr_ptr <= commit_ptr;
        drop   <= 1'b0;
      end else begin
        if (wr_valid && !wr_ready) begin
          drop <= 1'b1;
        end
        if (accept) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (commit) begin
          commit_ptr <= wr_ptr + PW'(1);
        end
      end

      if (load) begin
        rd_ptr   <= rd_ptr + PW'(1);
        rd_valid <= 1'b1;
      end else if (rd_fire) begin
        rd_valid <= 1'b0;
      end

      // A commit and a last-word read in the same cycle cancel out.
      case ({commit, rd_fire && rd_last})
        2'b10: if (pkt_count != PKT_MAX) pkt_count <= pkt_count + PKT_W'(1);
        2'b01: if (pkt_count != '0) pkt_count <= pkt_count - PKT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_pkt_fifo.sv
// tb/tb_usb_pkt_fifo.sv - directed self-checking bench for usb_pkt_fifo
module tb_usb_pkt_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       wr_discard;
  logic       wr_ready;
  logic       wr_afull;
  logic       wr_overflow;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_ready;
  logic [3:0] level;
  logic [3:0] pkt_count;

  int total;
  int bad;

  logic [7:0] got_data [12];
  logic       got_last [12];
  int         n;
  int         widx;

  usb_pkt_fifo #(
    .DATA_W    (8),
    .DEPTH     (8),
    .AFULL_LVL (6),
    .PKT_W     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_discard  (wr_discard),
    .wr_ready    (wr_ready),
    .wr_afull    (wr_afull),
    .wr_overflow (wr_overflow),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .rd_ready    (rd_ready),
    .level       (level),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && wr_valid && wr_last) begin
      assert (pkt_count != 4'hF) else $error("writer committed with pkt_count saturated");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic l);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = l;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = '0;
    wr_last = 1'b0;
    wr_discard = 1'b0;
    rd_ready = 1'b0;
    tick();
    tick();
    check_val("rst_rd_valid", 32'(rd_valid), 32'h0);
    check_val("rst_rd_data", 32'(rd_data), 32'h0);
    check_val("rst_level", 32'(level), 32'h0);
    check_val("rst_pkt", 32'(pkt_count), 32'h0);
    check_val("rst_ovf", 32'(wr_overflow), 32'h0);
    rst = 1'b0;
    #1;
    check_val("rst_wr_ready", 32'(wr_ready), 32'h1);

    // basic packet, latency and FWFT ordering
    rd_ready = 1'b1;
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b1);
    check_val("t1_lat_n1", 32'(rd_valid), 32'h0);
    check_val("t1_pkt1", 32'(pkt_count), 32'h1);
    check_val("t1_level3", 32'(level), 32'h3);
    tick();
    check_val("t1_valid_n2", 32'(rd_valid), 32'h1);
    check_val("t1_d0", 32'(rd_data), 32'h11);
    check_val("t1_l0", 32'(rd_last), 32'h0);
    tick();
    check_val("t1_d1", 32'(rd_data), 32'h22);
    check_val("t1_l1", 32'(rd_last), 32'h0);
    check_val("t1_level2", 32'(level), 32'h2);
    tick();
    check_val("t1_d2", 32'(rd_data), 32'h33);
    check_val("t1_l2", 32'(rd_last), 32'h1);
    check_val("t1_pkt_still1", 32'(pkt_count), 32'h1);
    tick();
    check_val("t1_empty", 32'(rd_valid), 32'h0);
    check_val("t1_pkt0", 32'(pkt_count), 32'h0);
    check_val("t1_level0", 32'(level), 32'h0);

    // discard of an open packet
    wr(8'hA0, 1'b0);
    wr(8'hA1, 1'b0);
    check_val("t2_level2", 32'(level), 32'h2);
    check_val("t2_no_read", 32'(rd_valid), 32'h0);
    wr_discard = 1'b1;
    tick();
    wr_discard = 1'b0;
    check_val("t2_level_disc", 32'(level), 32'h0);
    wr(8'hB0, 1'b1);
    check_val("t2_lat", 32'(rd_valid), 32'h0);
    tick();
    check_val("t2_valid", 32'(rd_valid), 32'h1);
    check_val("t2_data", 32'(rd_data), 32'hB0);
    check_val("t2_last", 32'(rd_last), 32'h1);
    tick();
    check_val("t2_empty", 32'(rd_valid), 32'h0);
    check_val("t2_level0", 32'(level), 32'h0);

    // fill without last, overflow, then rewind on last
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(8'(32'hC0 + i), 1'b0);
      if (i == 4) check_val("t3_afull_lo", 32'(wr_afull), 32'h0);
      if (i == 5) check_val("t3_afull_hi", 32'(wr_afull), 32'h1);
    end
    check_val("t3_full_ready", 32'(wr_ready), 32'h0);
    check_val("t3_level8", 32'(level), 32'h8);
    check_val("t3_no_read", 32'(rd_valid), 32'h0);
    wr_valid = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_valid = 1'b0;
    check_val("t3_ovf_pulse", 32'(wr_overflow), 32'h1);
    tick();
    check_val("t3_ovf_clear", 32'(wr_overflow), 32'h0);
    check_val("t3_level_hold", 32'(level), 32'h8);
    wr(8'hEF, 1'b1);
    check_val("t3_level_rewind", 32'(level), 32'h0);
    check_val("t3_ready_back", 32'(wr_ready), 32'h1);
    tick();
    tick();
    check_val("t3_rd_idle", 32'(rd_valid), 32'h0);
    check_val("t3_pkt0", 32'(pkt_count), 32'h0);

    // full committed packet, then read while writing with pointer wrap
    for (int i = 0; i < 8; i++) begin
      wr(8'(32'h50 + i), (i == 7));
    end
    check_val("t4_full", 32'(wr_ready), 32'h0);
    check_val("t4_pkt1", 32'(pkt_count), 32'h1);
    check_val("t4_level8", 32'(level), 32'h8);
    tick();
    check_val("t4_head_valid", 32'(rd_valid), 32'h1);
    got_data[0] = rd_data;
    got_last[0] = rd_last;
    rd_ready = 1'b1;
    tick();
    check_val("t4_ready_recover", 32'(wr_ready), 32'h1);
    check_val("t4_level7", 32'(level), 32'h7);
    n = 1;
    widx = 0;
    for (int cyc = 0; cyc < 40 && n < 12; cyc++) begin
      if (rd_valid) begin
        got_data[n] = rd_data;
        got_last[n] = rd_last;
        n++;
      end
      if (widx < 4 && wr_ready) begin
        wr_valid = 1'b1;
        wr_data = 8'(32'h60 + widx);
        wr_last = (widx == 3);
        widx++;
      end else begin
        wr_valid = 1'b0;
        wr_last = 1'b0;
      end
      tick();
    end
    wr_valid = 1'b0;
    wr_last = 1'b0;
    check_val("t4_count", 32'(n), 32'd12);
    for (int k = 0; k < 12; k++) begin
      check_val($sformatf("t4_data%0d", k), 32'(got_data[k]),
                (k < 8) ? 32'(32'h50 + k) : 32'(32'h60 + k - 8));
      check_val($sformatf("t4_last%0d", k), 32'(got_last[k]),
                ((k == 7) || (k == 11)) ? 32'h1 : 32'h0);
    end
    tick();
    check_val("t4_empty", 32'(rd_valid), 32'h0);
    check_val("t4_level0", 32'(level), 32'h0);
    check_val("t4_pkt0", 32'(pkt_count), 32'h0);

    // reset mid-packet with two committed packets
    rd_ready = 1'b0;
    wr(8'h71, 1'b1);
    wr(8'h72, 1'b1);
    wr(8'h73, 1'b0);
    check_val("t5_pkt2", 32'(pkt_count), 32'h2);
    rst = 1'b1;
    tick();
    check_val("t5_rd_valid", 32'(rd_valid), 32'h0);
    check_val("t5_pkt0", 32'(pkt_count), 32'h0);
    check_val("t5_level0", 32'(level), 32'h0);
    rst = 1'b0;
    #1;
    check_val("t5_wr_ready", 32'(wr_ready), 32'h1);

    // last-word read concurrent with a new commit; discard beats a write
    wr(8'h81, 1'b1);
    tick();
    check_val("t6_head", 32'(rd_data), 32'h81);
    check_val("t6_head_last", 32'(rd_last), 32'h1);
    check_val("t6_pkt1", 32'(pkt_count), 32'h1);
    rd_ready = 1'b1;
    wr(8'h82, 1'b1);
    rd_ready = 1'b0;
    check_val("t6_pkt_same", 32'(pkt_count), 32'h1);
    check_val("t6_level1", 32'(level), 32'h1);
    wr_discard = 1'b1;
    wr(8'h99, 1'b0);
    wr_discard = 1'b0;
    check_val("t6_disc_level", 32'(level), 32'h1);
    check_val("t6_disc_head", 32'(rd_data), 32'h82);
    rd_ready = 1'b1;
    tick();
    check_val("t6_empty", 32'(rd_valid), 32'h0);
    check_val("t6_level0", 32'(level), 32'h0);
    check_val("t6_pkt0", 32'(pkt_count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_pkt_fifo.md
Name: usb_pkt_fifo

Overview:
- Single-clock, parametrised packet FIFO; successor to the byte queue used between the USB PHY/SIE and endpoint logic.
- Adds valid/ready handshakes, first-word-fall-through (FWFT) read, a per-entry last flag, and packet commit/rollback, so corrupted RX packets (bad CRC, overflow) never reach the reader.
- Full capacity: DEPTH words usable, not DEPTH-1.

Parameters:
- DATA_W, 8, payload width in bits.
- DEPTH, 256, entries; power of two, >= 4.
- AFULL_LVL, DEPTH-8, wr_afull asserts when level >= AFULL_LVL.
- PKT_W, 8, pkt_count width; max outstanding committed packets is 2^PKT_W-1.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- wr_valid  in  1  write request.
- wr_data  in  DATA_W  write payload.
- wr_last  in  1  final word of packet; commits the packet when accepted.
- wr_discard  in  1  drop the open (uncommitted) packet.
- wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready.
- wr_afull  out  1  level >= AFULL_LVL.
- wr_overflow  out  1  one-cycle pulse: wr_valid while !wr_ready.
- rd_valid  out  1  rd_data/rd_last valid (FWFT).
- rd_data  out  DATA_W  head word.
- rd_last  out  1  head word is last of its packet.
- rd_ready  in  1  consume head when rd_valid.
- level  out  $clog2(DEPTH)+1  words stored, committed + uncommitted, including the output register.
- pkt_count  out  PKT_W  committed packets not yet fully read.

Behaviour:
- Reset: all pointers 0; drop flag 0; rd_valid, rd_data, rd_last, wr_overflow, level, pkt_count = 0; wr_ready = 1 on the first cycle after reset.
- Pointers: wr_ptr, commit_ptr, rd_ptr, each $clog2(DEPTH)+1 bits.
  - Full: MSB differs and the lower bits are equal.
  - Empty for reading: rd_ptr == commit_ptr.
  - All pointers wrap modulo 2*DEPTH.
- Memory entry: {last, data}, DATA_W+1 bits.
- Write:
  - wr_ready = !full & !rst.
  - An accepted word is written at wr_ptr and wr_ptr increments.
  - If wr_last is accepted and drop=0, commit_ptr <= wr_ptr+1 and pkt_count increments.
- Overflow: wr_valid & !wr_ready pulses wr_overflow next cycle and sets drop=1.
  - While drop=1, incoming words are ignored.
  - The next wr_valid & wr_last (ready or not) rewinds wr_ptr to commit_ptr and clears drop; no commit occurs.
- Discard: wr_discard rewinds wr_ptr to commit_ptr and clears drop.
  - Same cycle as wr_valid: discard wins and the word is not written.
  - With no open packet: no-op.
- Read: FWFT through a registered head stage fed by 1-cycle synchronous RAM.
  - Latency: wr_last handshake at cycle N gives rd_valid=1 at N+2 when the FIFO was empty.
  - Sustains one word per cycle with rd_ready held high; no bubbles while committed data remains.
  - rd_valid & rd_ready & rd_last decrements pkt_count.
  - Commit and last-word read in the same cycle leave pkt_count unchanged.
  - Uncommitted words are never presented.
- Level: +1 per accepted write, -1 per read handshake, -(wr_ptr-commit_ptr) on rewind; all applied in the same cycle. Level never exceeds DEPTH.
- pkt_count saturates at max; the writer must not exceed it (assertion in the bench).
- Reset mid-packet or mid-read: everything is lost; rd_valid=0 and pkt_count=0 from the next cycle.

Decomposition:
- Package usb_fifo_pkg: pointer-width function (clog2+1), LAST bit index constant, entry width macro.
- Sub-module sdp_ram: simple dual-port RAM, registered read, block-RAM style attribute, parameters WIDTH/DEPTH, no reset on the array.

Test Plan:
- Write packet 0x11,0x22,0x33 (last on 0x33), rd_ready=1 -> rd_valid 2 cycles after the last word; reads 0x11,0x22,0x33 with rd_last only on 0x33; pkt_count 1 -> 0.
- Write 0xA0,0xA1 then wr_discard, then packet 0xB0(last) -> only 0xB0 is read; level returns to 0.
- DEPTH=8: write 8 words without last -> wr_ready=0, level=8; 9th wr_valid -> wr_overflow pulse; wr_valid+wr_last -> level=0, rd_valid stays 0.
- Fill 8 words with wr_last on the 8th, read while writing a new 4-word packet -> pointers wrap; data order is preserved; wr_ready recovers after the first read.
- rst asserted mid-packet with 2 committed packets -> next cycle rd_valid=0, pkt_count=0, level=0, wr_ready=1.
- Simultaneous last-word read and new commit -> pkt_count unchanged that cycle; wr_discard with wr_valid -> word not stored.
